// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 16x-oversampling serial frame receiver with a small
// receive buffer. Decodes 5-8 data bits, optional even/odd parity and
// 1 or 2 stop bits, and presents {fe, pe, data} on a valid/ready port.
//
// Ports:
//   sys_clk, rst_b        clock, asynchronous active-low reset
//   s_in                  serial line (idle high)
//   cfg_divisor           sys_clk cycles per oversample tick (0 acts as 1)
//   cfg_dls/pen/eps/stop  frame format, latched at start-bit detection
//   rx_data/rx_pe/rx_fe   head entry of the buffer (0 while empty)
//   rx_vld / rx_rdy       buffer non-empty / consumer accepts head entry
//   ovf / ovf_clr         sticky dropped-frame flag and its clear
//   busy                  receiver is inside a frame (registered)
module uart_rx_capture #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        sys_clk,
  input  logic        rst_b,
  input  logic        s_in,
  input  logic [15:0] cfg_divisor,
  input  logic [1:0]  cfg_dls,
  input  logic        cfg_pen,
  input  logic        cfg_eps,
  input  logic        cfg_stop,
  output logic [7:0]  rx_data,
  output logic        rx_pe,
  output logic        rx_fe,
  output logic        rx_vld,
  input  logic        rx_rdy,
  output logic        ovf,
  input  logic        ovf_clr,
  output logic        busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HIGH
  } state_e;

  // Input synchronizer; both stages reset to the idle level.
  logic sync1_q, line_q;

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      sync1_q <= 1'b1;
      line_q  <= 1'b1;
    end else begin
      sync1_q <= s_in;
      line_q  <= sync1_q;
    end
  end

  // Free-running tick generator. The >= compare lets a divisor decrease
  // take effect immediately instead of waiting for a counter wrap.
  logic [15:0] tcnt_q, tcnt_d, div_m1;
  logic        tick;

  always_comb begin
    div_m1 = (cfg_divisor == '0) ? '0 : cfg_divisor - 16'd1;
    tick   = (tcnt_q >= div_m1);
    tcnt_d = tick ? '0 : tcnt_q + 16'd1;
  end

  // Frame decoder state
  state_e      state_q, state_d;
  logic [3:0]  os_q, os_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        pe_q, pe_d, fe_q, fe_d;
  logic [1:0]  dls_q, dls_d;
  logic        pen_q, pen_d, eps_q, eps_d, stop_q, stop_d;
  logic        busy_q;
  logic        mid, fe_now, push;
  logic [2:0]  last_idx;

  assign mid      = tick && (os_q == 4'd7);
  assign fe_now   = fe_q | ~line_q;
  assign last_idx = {1'b0, dls_q} + 3'd4;

  always_comb begin
    state_d = state_q;
    os_d    = tick ? os_q + 4'd1 : os_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    dls_d   = dls_q;
    pen_d   = pen_q;
    eps_d   = eps_q;
    stop_d  = stop_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!line_q) begin
          state_d = S_START;
          os_d    = '0;
          shreg_d = '0;
          pe_d    = 1'b0;
          fe_d    = 1'b0;
          dls_d   = cfg_dls;
          pen_d   = cfg_pen;
          eps_d   = cfg_eps;
          stop_d  = cfg_stop;
        end
      end
      S_START: begin
        if (mid) begin
          if (line_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (mid) begin
          shreg_d[idx_q] = line_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == last_idx) state_d = pen_q ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: begin
        // Unused upper bits of shreg are zero, so ^shreg is the data parity.
        if (mid) begin
          pe_d    = (((^shreg_q) ^ line_q) == eps_q);
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (mid) begin
          fe_d = fe_now;
          if (stop_q) begin
            state_d = S_STOP2;
          end else begin
            push    = 1'b1;
            state_d = fe_now ? S_WAIT_HIGH : S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (mid) begin
          fe_d    = fe_now;
          push    = 1'b1;
          state_d = fe_now ? S_WAIT_HIGH : S_IDLE;
        end
      end
      S_WAIT_HIGH: begin
        if (line_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      tcnt_q  <= '0;
      state_q <= S_IDLE;
      os_q    <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      dls_q   <= '0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      state_q <= state_d;
      os_q    <= os_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      dls_q   <= dls_d;
      pen_q   <= pen_d;
      eps_q   <= eps_d;
      stop_q  <= stop_d;
      busy_q  <= (state_q != S_IDLE);
    end
  end

  // Receive buffer
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q, full, empty, pop, push_ok;
  logic [9:0]    push_word, head;

  assign full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign pop       = !empty && rx_rdy;
  // A pop in the same cycle frees the slot a full buffer needs.
  assign push_ok   = push && (!full || pop);
  assign push_word = {fe_now, pe_q, shreg_q};

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (!push_ok && pop) cnt_q <= cnt_q - (AW+1)'(1);
      if (push && !push_ok)     ovf_q <= 1'b1;
      else if (ovf_clr)         ovf_q <= 1'b0;
    end
  end

  assign head    = empty ? '0 : mem[rd_ptr_q];
  assign rx_data = head[7:0];
  assign rx_pe   = head[8];
  assign rx_fe   = head[9];
  assign rx_vld  = !empty;
  assign ovf     = ovf_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
module tb_uart_rx_capture;

  localparam int unsigned DEPTH = 8;

  logic        sys_clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        s_in = 1'b1;
  logic [15:0] cfg_divisor = 16'd1;
  logic [1:0]  cfg_dls = 2'd3;
  logic        cfg_pen = 1'b0, cfg_eps = 1'b0, cfg_stop = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_pe, rx_fe, rx_vld, rx_rdy, ovf, busy;
  logic        ovf_clr = 1'b0;

  logic rdy_man = 1'b0, rdy_rnd = 1'b0, rnd_mode = 1'b0;
  assign rx_rdy = rnd_mode ? rdy_rnd : rdy_man;

  int unsigned n_vec = 0, n_err = 0;
  logic [9:0]  exp_q[$];
  logic        exp_ovf = 1'b0;

  uart_rx_capture #(.FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .rst_b(rst_b), .s_in(s_in),
    .cfg_divisor(cfg_divisor), .cfg_dls(cfg_dls), .cfg_pen(cfg_pen),
    .cfg_eps(cfg_eps), .cfg_stop(cfg_stop),
    .rx_data(rx_data), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_vld(rx_vld),
    .rx_rdy(rx_rdy), .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected buffer entry for one transmitted frame.
  function automatic logic [9:0] model_frame(input logic [7:0] b, input logic [1:0] dls,
                                             input logic pen, input logic stop,
                                             input logic flip_par, input logic [1:0] bad_stop);
    logic [7:0] mask;
    mask = 8'((32'd1 << (5 + dls)) - 32'd1);
    return {bad_stop[0] | (stop & bad_stop[1]), pen & flip_par, b & mask};
  endfunction

  function automatic void model_push(input logic [9:0] e);
    if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(e);
  endfunction

  // Consumer-side scoreboard: every accepted head entry is checked in order.
  always @(negedge sys_clk) begin
    if (rst_b && rx_vld && rx_rdy) begin
      if (exp_q.size() == 0) check_eq("spurious_vld", rx_vld, 0);
      else check_eq("rx_entry", {rx_fe, rx_pe, rx_data}, exp_q.pop_front());
    end
  end

  always @(posedge sys_clk) begin
    #2;
    rdy_rnd = 1'($urandom_range(0, 1));
  end

  task automatic drive_bit(input logic v, input int unsigned bp);
    s_in = v;
    repeat (bp) @(negedge sys_clk);
  endtask

  task automatic idle_bits(input int unsigned nb, input logic [15:0] div);
    drive_bit(1'b1, nb * 16 * ((div == 0) ? 1 : div));
  endtask

  task automatic set_man_rdy(input logic v);
    @(posedge sys_clk);
    #2 rdy_man = v;
  endtask

  // Starts the start bit immediately (caller is on a negedge).
  task automatic send_frame(input logic [7:0] b, input logic [15:0] div, input logic [1:0] dls,
                            input logic pen, input logic eps, input logic stop,
                            input logic flip_par, input logic [1:0] bad_stop, input logic scramble);
    int unsigned bp, n;
    logic [7:0]  d;
    logic        par;
    bp = 16 * ((div == 0) ? 1 : div);
    n  = 5 + dls;
    d  = b & 8'((32'd1 << n) - 32'd1);
    par = (eps ? ^d : ~^d) ^ flip_par;
    cfg_divisor = div; cfg_dls = dls; cfg_pen = pen; cfg_eps = eps; cfg_stop = stop;
    drive_bit(1'b0, bp);
    if (scramble) begin
      cfg_dls = 2'($urandom); cfg_pen = 1'($urandom); cfg_eps = 1'($urandom); cfg_stop = 1'($urandom);
    end
    for (int unsigned i = 0; i < n; i++) drive_bit(d[i], bp);
    if (pen) drive_bit(par, bp);
    drive_bit(~bad_stop[0], bp);
    if (stop) drive_bit(~bad_stop[1], bp);
    s_in = 1'b1;
    cfg_dls = dls; cfg_pen = pen; cfg_eps = eps; cfg_stop = stop;
  endtask

  task automatic drain(input string tag);
    set_man_rdy(1'b1);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !rx_vld) break;
      @(negedge sys_clk);
    end
    check_eq({tag, "_vld"}, rx_vld, 0);
    check_eq({tag, "_left"}, exp_q.size(), 0);
    check_eq({tag, "_data0"}, {rx_fe, rx_pe, rx_data}, 0);
    set_man_rdy(1'b0);
    @(negedge sys_clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [15:0] div;
    logic [1:0] dls, bad;
    logic pen, eps, stop, flip;

    // Reset values
    repeat (3) @(negedge sys_clk);
    check_eq("rst_vld", rx_vld, 0);
    check_eq("rst_data", rx_data, 0);
    check_eq("rst_pe", rx_pe, 0);
    check_eq("rst_fe", rx_fe, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_busy", busy, 0);
    rst_b = 1'b1;
    idle_bits(1, 1);

    // 8N1 0xA5: entry visible one cycle after the mid-stop sample edge
    model_push(model_frame(8'hA5, 2'd3, 0, 0, 0, 2'b00));
    fork
      send_frame(8'hA5, 16'd1, 2'd3, 0, 0, 0, 0, 2'b00, 0);
      begin
        repeat (80) @(posedge sys_clk);
        #1 check_eq("basic_busy_mid", busy, 1);
        repeat (74) @(posedge sys_clk);
        @(negedge sys_clk) check_eq("basic_vld_before", rx_vld, 0);
        @(negedge sys_clk) check_eq("basic_vld_after", rx_vld, 1);
        check_eq("basic_data", {rx_fe, rx_pe, rx_data}, 10'h0A5);
      end
    join
    check_eq("basic_busy_end", busy, 0);
    drain("basic");

    // 5E2 0x13, correct then inverted parity
    model_push(model_frame(8'h13, 2'd0, 1, 1, 0, 2'b00));
    send_frame(8'h13, 16'd1, 2'd0, 1, 1, 1, 0, 2'b00, 0);
    idle_bits(2, 1);
    model_push(model_frame(8'h13, 2'd0, 1, 1, 1, 2'b00));
    send_frame(8'h13, 16'd1, 2'd0, 1, 1, 1, 1, 2'b00, 0);
    idle_bits(2, 1);
    check_eq("5e2_first", {rx_fe, rx_pe, rx_data}, 10'h013);
    drain("5e2");

    // 5-clock glitch is a false start
    s_in = 1'b0;
    repeat (5) @(negedge sys_clk);
    idle_bits(2, 1);
    check_eq("glitch_busy", busy, 0);
    check_eq("glitch_vld", rx_vld, 0);

    // Break: one fe entry with data 0, receiver parked until line high
    cfg_divisor = 16'd1; cfg_dls = 2'd3; cfg_pen = 0; cfg_stop = 0;
    model_push(10'h200);
    drive_bit(1'b0, 20 * 16);
    check_eq("break_busy", busy, 1);
    check_eq("break_entry", {rx_vld, rx_fe, rx_pe, rx_data}, 11'h600);
    idle_bits(2, 1);
    check_eq("break_idle", busy, 0);
    drain("break");
    model_push(model_frame(8'h55, 2'd3, 0, 0, 0, 2'b00));
    send_frame(8'h55, 16'd1, 2'd3, 0, 0, 0, 0, 2'b00, 0);
    idle_bits(1, 1);
    drain("after_break");

    // Overflow: 9 frames into an 8-entry buffer with no consumer
    for (int unsigned i = 0; i < 9; i++) begin
      model_push(model_frame(8'(i), 2'd3, 0, 0, 0, 2'b00));
      send_frame(8'(i), 16'd1, 2'd3, 0, 0, 0, 0, 2'b00, 0);
      idle_bits(1, 1);
    end
    check_eq("ovf_set", ovf, exp_ovf);
    drain("ovf");
    check_eq("ovf_sticky", ovf, 1);
    @(posedge sys_clk); #2 ovf_clr = 1'b1;
    @(posedge sys_clk); #2 ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    @(negedge sys_clk) check_eq("ovf_clr", ovf, 0);

    // Full buffer: pop in the exact push cycle lets the 9th frame in
    for (int unsigned i = 0; i < 8; i++) begin
      model_push(model_frame(8'h10 + 8'(i), 2'd3, 0, 0, 0, 2'b00));
      send_frame(8'h10 + 8'(i), 16'd1, 2'd3, 0, 0, 0, 0, 2'b00, 0);
      idle_bits(1, 1);
    end
    fork
      send_frame(8'h99, 16'd1, 2'd3, 0, 0, 0, 0, 2'b00, 0);
      begin
        repeat (154) @(posedge sys_clk);
        #2 rdy_man = 1'b1;
        @(posedge sys_clk);
        #2 rdy_man = 1'b0;
      end
    join
    model_push(model_frame(8'h99, 2'd3, 0, 0, 0, 2'b00));
    idle_bits(1, 1);
    check_eq("full_pp_ovf", ovf, 0);
    check_eq("full_pp_head", rx_data, 8'h11);
    drain("full_pp");

    // Reset during data bit 3 discards the frame
    fork
      send_frame(8'hC3, 16'd1, 2'd3, 0, 0, 0, 0, 2'b00, 0);
      begin
        repeat (72) @(negedge sys_clk);
        check_eq("midrst_busy_pre", busy, 1);
        rst_b = 1'b0;
        #1;
        check_eq("midrst_outs", {rx_vld, rx_fe, rx_pe, rx_data, ovf, busy}, 0);
      end
    join
    rst_b = 1'b1;
    idle_bits(2, 1);
    check_eq("midrst_vld", rx_vld, 0);
    model_push(model_frame(8'h3C, 2'd3, 0, 0, 0, 2'b00));
    send_frame(8'h3C, 16'd1, 2'd3, 0, 0, 0, 0, 2'b00, 0);
    idle_bits(1, 1);
    drain("midrst");

    // Randomized frames, formats, divisors, errors and consumer stalls
    @(posedge sys_clk); #2 rnd_mode = 1'b1;
    @(negedge sys_clk);
    for (int unsigned i = 0; i < 30; i++) begin
      b    = 8'($urandom);
      div  = 16'($urandom_range(0, 3));
      dls  = 2'($urandom);
      pen  = 1'($urandom);
      eps  = 1'($urandom);
      stop = 1'($urandom);
      flip = 1'($urandom);
      bad  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      model_push(model_frame(b, dls, pen, stop, flip, bad));
      send_frame(b, div, dls, pen, eps, stop, flip, bad, 1);
      idle_bits($urandom_range(1, 3), div);
    end
    @(posedge sys_clk); #2 rnd_mode = 1'b0;
    drain("rand");
    check_eq("rand_ovf", ovf, exp_ovf);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
